// File: rtl/conv_encoder_gen.sv
// Rate-1/2 convolutional encoder with K-1 zero-tail termination; emits parallel codeword and state path.
// Optional macro CONV_SERIAL_OUT_EN adds per-step sym/sym_valid outputs.
module conv_encoder_gen #(
    parameter int             MSG_W = 12,
    parameter int             K     = 3,
    parameter logic [K-1:0]   G0    = 3'b111,
    parameter logic [K-1:0]   G1    = 3'b101
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MSG_W-1:0]       x,
    output logic                   busy,
    output logic                   done,
    output logic [2*(MSG_W+K-1)-1:0]     op,
    output logic [(K-1)*(MSG_W+K-1)-1:0] path
`ifdef CONV_SERIAL_OUT_EN
    ,
    output logic                   sym_valid,
    output logic [1:0]             sym
`endif
);

    localparam int N   = MSG_W + K - 1;
    localparam int SW  = K - 1;
    localparam int CW  = $clog2(N + 1);
    localparam int OPW = 2 * N;
    localparam int PW  = SW * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [MSG_W-1:0] x_reg;
    logic [SW-1:0]    s_reg;
    logic [SW-1:0]    s_next;
    logic [CW-1:0]    cnt_reg;
    logic [OPW-1:0]   op_reg;
    logic [PW-1:0]    path_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             in_bit;
    logic [K-1:0]     taps;
    logic             o0;
    logic             o1;
    logic             last_step;

    // The latched message shifts left each step, so zeros flow in as the tail bits.
    assign in_bit    = x_reg[MSG_W-1];
    assign taps      = {in_bit, s_reg};
    assign o0        = ^(taps & G0);
    assign o1        = ^(taps & G1);
    assign last_step = (cnt_reg == CW'(N - 1));

    generate
        if (K > 2) begin : g_sreg_wide
            assign s_next = {in_bit, s_reg[SW-1:1]};
        end else begin : g_sreg_one
            assign s_next = in_bit;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ENC;
            ENC:     if (last_step) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            s_reg     <= '0;
            cnt_reg   <= '0;
            op_reg    <= '0;
            path_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == FIN);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg    <= x;
                        s_reg    <= '0;
                        cnt_reg  <= '0;
                        op_reg   <= '0;
                        path_reg <= '0;
                    end
                end
                ENC: begin
                    x_reg    <= {x_reg[MSG_W-2:0], 1'b0};
                    s_reg    <= s_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    op_reg   <= {op_reg[OPW-3:0], o0, o1};
                    path_reg <= {path_reg[PW-SW-1:0], s_next};
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign op   = op_reg;
    assign path = path_reg;

`ifdef CONV_SERIAL_OUT_EN
    logic       sym_valid_reg;
    logic [1:0] sym_reg;

    // One symbol per ENC step; the final symbol lands in the same cycle as done.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_valid_reg <= 1'b0;
            sym_reg       <= 2'b00;
        end else begin
            sym_valid_reg <= (state_reg == ENC);
            if (state_reg == ENC) begin
                sym_reg <= {o0, o1};
            end
        end
    end

    assign sym_valid = sym_valid_reg;
    assign sym       = sym_reg;
`endif

endmodule

// File: doc/conv_encoder_gen.md
CONV_ENCODER_GEN -- requirements
Module: conv_encoder_gen

Interface
REQ-001 Parameter MSG_W, default 12: message length in bits.
REQ-002 Parameter K, default 3, legal range 2..7: constraint length.
REQ-003 Parameter G0, default 3'b111 (K bits): generator polynomial for output bit 0.
REQ-004 Parameter G1, default 3'b101 (K bits): generator polynomial for output bit 1.
REQ-005 Derived constant N = MSG_W+K-1: encode steps, covering the message plus K-1 zero tail bits.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request to encode x; sampled only in IDLE.
REQ-009 x  input  MSG_W  message word; MSB is encoded first.
REQ-010 busy  output  1  high while the block is not in IDLE.
REQ-011 done  output  1  one-cycle pulse when op and path are complete.
REQ-012 op  output  2*N  codeword; step 1 is in the two MSBs, each pair is {o0,o1}.
REQ-013 path  output  (K-1)*N  encoder state after each step; step 1 is in the MSBs.

Function
REQ-014 The FSM SHALL have three states:
  - IDLE -> ENC when start=1; x is latched, the shift register, step counter, op and path are cleared.
  - ENC -> FIN after step N.
  - FIN -> IDLE unconditionally.
REQ-015 Each ENC cycle SHALL process one input bit:
  - bit = latched x, MSB first, for steps 1..MSG_W; 0 for steps MSG_W+1..N.
  - Shift register s has K-1 bits; s[K-2] is the most recent bit.
REQ-016 Tap vector v = {bit, s}. o0 = XOR of (v AND G0); o1 = XOR of (v AND G1). Generator bit K-1 taps the current input.
REQ-017 Per step:
  - op shifts left 2 and loads {o0,o1}.
  - path shifts left K-1 and loads the next s.
  - s becomes {bit, s[K-2:1]}.
REQ-018 busy SHALL be 1 in ENC and FIN, and 0 in IDLE.
REQ-019 done SHALL be 1 only in FIN, exactly N+1 cycles after the edge that accepted start.
REQ-020 op and path SHALL hold their final values from FIN until the next accepted start.
REQ-021 start asserted in ENC or FIN SHALL be ignored; it is neither queued nor able to corrupt the current encode.
REQ-022 Changes on x after acceptance SHALL NOT affect the current encode.
REQ-023 start held high continuously SHALL restart encoding on the cycle after FIN returns to IDLE; the gap between done pulses is N+2 cycles.
REQ-024 The encoder SHALL always terminate to the all-zero state; the last K-1 path entries are zero.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL clear state to IDLE and clear s, counter, op, path, busy, done, sym and sym_valid to 0.
REQ-026 reset SHALL take priority over start and SHALL abort an encode in progress without producing a done pulse.

Configuration
REQ-027 Macro CONV_SERIAL_OUT_EN SHALL control the serial symbol outputs.
REQ-028 When CONV_SERIAL_OUT_EN is defined, the block SHALL add sym_valid (output, 1) and sym (output, 2), registered with the op shift:
  - sym = {o0,o1} of the step just processed.
  - sym_valid is high for exactly N consecutive cycles, the last coinciding with done.
REQ-029 When CONV_SERIAL_OUT_EN is undefined, the sym and sym_valid ports and their logic SHALL be absent; the parallel behaviour is unchanged.

Verification
REQ-030 Defaults; reset then start with x=12'b111010000000 -> done N+1=15 cycles later, op=28'hD92C000, path=28'hBD90000.
REQ-031 Defaults; x=12'h800 -> op=28'hEC00000, path=28'h9000000; x=12'h000 -> op=0, path=0, done still pulses.
REQ-032 start pulsed in ENC and x changed during ENC -> the result equals the originally latched x; a single done pulse occurs.
REQ-033 reset asserted at ENC step 5 -> the next cycle has busy=0, op=0, path=0; no done pulse; a new start then encodes correctly.
REQ-034 start held high for 40 cycles -> done pulses are 16 cycles apart; op is identical each run.
REQ-035 With CONV_SERIAL_OUT_EN, x=12'b111010000000 -> sym sequence 3,1,2,1,0,2,3,0,0,0,0,0,0,0 over 14 valid cycles.
